timer_counter_n: RTL and testbench

- Parametrised successor to the 8-bit timer counter.
- Adds the following to the width-generic up/down counter with sticky overflow/underflow:
  - an internal programmable prescaler, which replaces the externally generated clk_ena;
  - auto-reload;
  - one-shot mode;
  - a sticky compare-match flag.
- Sits between the register interface (which owns load/clear strobes and configuration) and the interrupt logic (which consumes the sticky flags).

---
 rtl/timer_counter_n_pkg.sv | 18 +
 rtl/timer_counter_n_prescaler.sv | 37 +++
 rtl/timer_counter_n.sv | 117 +++++++++++
 tb/tb_timer_counter_n.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_n_pkg.sv
// Shared definitions for the timer counter family: direction encodings and
// width helpers used by the counter and its prescaler.
package timer_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Largest value representable in a counter of the given width.
  function automatic logic [63:0] cnt_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  // The free-running divider must be wide enough for the largest select value.
  function automatic int div_w(input int psc_w);
    return 1 << psc_w;
  endfunction

endpackage : timer_pkg

// File: rtl/timer_counter_n_prescaler.sv
// Free-running divider with a selectable one-cycle tick every 2**(cks+1) clocks.
// Changing cks takes effect immediately and never disturbs the divider.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PSC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PSC_W-1:0] cks,
  output logic             tick
);

  localparam int DIV_W = div_w(PSC_W);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Bits [cks:0] of the divider take part in the all-ones decode.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DIV_W; i++) begin
      w_mask[i] = (PSC_W'(i) <= cks);
    end
  end

  assign tick = &(r_div | ~w_mask);

endmodule : timer_prescaler

// File: rtl/timer_counter_n.sv
// Width-generic up/down timer with internal prescaler, auto-reload, one-shot
// mode and sticky overflow/underflow/compare-match flags.
module timer_counter_n
  import timer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PSC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PSC_W-1:0] cks,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reload_en,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  input  logic             clr_cmp,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             cmp_match,
  output logic             tick,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_running;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_cmpMatch;

  logic             w_tick;
  logic             w_step;
  logic             w_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_setOvf;
  logic             w_setUnf;
  logic             w_setCmp;

  timer_prescaler #(
    .PSC_W(PSC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cks  (cks),
    .tick (w_tick)
  );

  // A load in the same cycle as a tick swallows that step.
  assign w_step = enable & r_running & w_tick & ~load;

  // Next count for a step; wrap target is the reload register or the natural end.
  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (up_down == DIR_UP) begin
      if (r_count == MAX) begin
        w_wrap = 1'b1;
        w_next = reload_en ? r_reload : '0;
      end else begin
        w_next = r_count + WIDTH'(1);
      end
    end else begin
      if (r_count == '0) begin
        w_wrap = 1'b1;
        w_next = reload_en ? r_reload : MAX;
      end else begin
        w_next = r_count - WIDTH'(1);
      end
    end
  end

  assign w_setOvf = w_step & w_wrap & (up_down == DIR_UP);
  assign w_setUnf = w_step & w_wrap & (up_down == DIR_DOWN);
  assign w_setCmp = w_step & (w_next == cmp_value);

  // Flags are sticky; a set in the same cycle as its clear strobe wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_reload    <= '0;
      r_running   <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_cmpMatch  <= 1'b0;
    end else begin
      if (load) begin
        r_count   <= load_value;
        r_reload  <= load_value;
        r_running <= 1'b1;
      end else if (w_step) begin
        r_count <= w_next;
        if (w_wrap && one_shot) begin
          r_running <= 1'b0;
        end
      end
      r_overflow  <= w_setOvf | (r_overflow & ~clr_overflow);
      r_underflow <= w_setUnf | (r_underflow & ~clr_underflow);
      r_cmpMatch  <= w_setCmp | (r_cmpMatch & ~clr_cmp);
    end
  end

  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign cmp_match = r_cmpMatch;
  assign running   = r_running;
  assign tick      = w_tick;

endmodule : timer_counter_n

// File: tb/tb_timer_counter_n.sv
// Self-checking bench: an arithmetic model of the 8-bit timer is compared every
// cycle, plus directed literal checks on it and on a 12-bit instance.
module tb_timer_counter_n;

  logic       clk;
  logic       rst;
  logic [2:0] cks;
  logic       enable, up_down, load, reload_en, one_shot;
  logic [7:0] load_value, cmp_value;
  logic       clr_overflow, clr_underflow, clr_cmp;
  logic [7:0] count;
  logic       overflow, underflow, cmp_match, tick, running;

  logic        b_rst;
  logic [1:0]  b_cks;
  logic        b_enable, b_up_down, b_load, b_reload_en, b_one_shot;
  logic [11:0] b_load_value, b_cmp_value;
  logic        b_clr_overflow, b_clr_underflow, b_clr_cmp;
  logic [11:0] b_count;
  logic        b_overflow, b_underflow, b_cmp_match, b_tick, b_running;

  int nChecks = 0;
  int nFails  = 0;
  bit checkOn = 1'b0;
  int waited;

  timer_counter_n #(.WIDTH(8), .PSC_W(3)) dut (
    .clk(clk), .rst(rst), .cks(cks), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .reload_en(reload_en),
    .one_shot(one_shot), .cmp_value(cmp_value), .clr_overflow(clr_overflow),
    .clr_underflow(clr_underflow), .clr_cmp(clr_cmp), .count(count),
    .overflow(overflow), .underflow(underflow), .cmp_match(cmp_match),
    .tick(tick), .running(running)
  );

  timer_counter_n #(.WIDTH(12), .PSC_W(2)) dutB (
    .clk(clk), .rst(b_rst), .cks(b_cks), .enable(b_enable), .up_down(b_up_down),
    .load(b_load), .load_value(b_load_value), .reload_en(b_reload_en),
    .one_shot(b_one_shot), .cmp_value(b_cmp_value), .clr_overflow(b_clr_overflow),
    .clr_underflow(b_clr_underflow), .clr_cmp(b_clr_cmp), .count(b_count),
    .overflow(b_overflow), .underflow(b_underflow), .cmp_match(b_cmp_match),
    .tick(b_tick), .running(b_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int rel;
    int div;
    bit ovf;
    bit unf;
    bit cmp;
    bit run;
  } model_t;

  model_t m = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Tick whenever the low cks+1 bits of the free-running count are all ones.
  function automatic bit modelTick(input int div, input int sel);
    int period;
    period = 1 << (sel + 1);
    return (div % period) == (period - 1);
  endfunction

  function automatic model_t modelNext(input model_t s);
    model_t n;
    bit stepping, setO, setU, setC, wrap;
    int nxt;
    n = s;
    setO = 1'b0; setU = 1'b0; setC = 1'b0; wrap = 1'b0;
    nxt = s.cnt;
    if (rst) begin
      n = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
      return n;
    end
    n.div = (s.div + 1) % 256;
    stepping = enable && s.run && modelTick(s.div, int'(cks)) && !load;
    if (load) begin
      n.cnt = int'(load_value);
      n.rel = int'(load_value);
      n.run = 1'b1;
    end else if (stepping) begin
      if (up_down) begin
        if (s.cnt == 255) begin setO = 1'b1; wrap = 1'b1; nxt = reload_en ? s.rel : 0; end
        else nxt = s.cnt + 1;
      end else begin
        if (s.cnt == 0) begin setU = 1'b1; wrap = 1'b1; nxt = reload_en ? s.rel : 255; end
        else nxt = s.cnt - 1;
      end
      n.cnt = nxt;
      setC = (nxt == int'(cmp_value));
      if (wrap && one_shot) n.run = 1'b0;
    end
    n.ovf = setO || (s.ovf && !clr_overflow);
    n.unf = setU || (s.unf && !clr_underflow);
    n.cmp = setC || (s.cmp && !clr_cmp);
    return n;
  endfunction

  always @(posedge clk) begin
    m <= modelNext(m);
    if (rst) checkOn <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("model count", 32'(count), m.cnt);
      checkOutput("model overflow", 32'(overflow), 32'(m.ovf));
      checkOutput("model underflow", 32'(underflow), 32'(m.unf));
      checkOutput("model cmp_match", 32'(cmp_match), 32'(m.cmp));
      checkOutput("model running", 32'(running), 32'(m.run));
      checkOutput("model tick", 32'(tick), 32'(modelTick(m.div, int'(cks))));
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Step until the selected instance shows a tick now; report clocks waited.
  task automatic advanceToTick(input bit useB, output int w);
    bit found;
    found = 1'b0;
    w = -1;
    for (int i = 0; i < 64; i++) begin
      if ((useB ? b_tick : tick) === 1'b1) begin
        w = i;
        found = 1'b1;
        break;
      end
      applyStimulus();
    end
    if (!found) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL tick timeout: got no tick in 64 clocks, expected one");
    end
  endtask

  initial begin
    rst = 1'b1; cks = 3'd0; enable = 1'b1; up_down = 1'b0; load = 1'b0;
    load_value = 8'h00; reload_en = 1'b0; one_shot = 1'b0; cmp_value = 8'h80;
    clr_overflow = 1'b0; clr_underflow = 1'b0; clr_cmp = 1'b0;
    b_rst = 1'b1; b_cks = 2'd0; b_enable = 1'b0; b_up_down = 1'b1; b_load = 1'b0;
    b_load_value = 12'h000; b_reload_en = 1'b0; b_one_shot = 1'b0;
    b_cmp_value = 12'h800; b_clr_overflow = 1'b0; b_clr_underflow = 1'b0;
    b_clr_cmp = 1'b0;

    // Reset, then the first down tick wraps 0 to 255
    repeat (5) applyStimulus();
    rst = 1'b0; b_rst = 1'b0;
    checkOutput("reset count", 32'(count), 32'h0);
    checkOutput("reset flags", {29'd0, overflow, underflow, cmp_match}, 32'h0);
    checkOutput("reset tick", 32'(tick), 32'h0);
    advanceToTick(1'b0, waited);
    checkOutput("first tick cycle", waited, 32'd1);
    applyStimulus();
    checkOutput("underflow wrap count", 32'(count), 32'hFF);
    checkOutput("underflow set", 32'(underflow), 32'h1);
    checkOutput("overflow stays", 32'(overflow), 32'h0);

    // Auto-reload up count; set beats clear on the wrapping cycle
    load = 1'b1; load_value = 8'hFD; up_down = 1'b1; reload_en = 1'b1; cks = 3'd2;
    applyStimulus();
    load = 1'b0;
    checkOutput("load FD", 32'(count), 32'hFD);
    advanceToTick(1'b0, waited); applyStimulus();
    checkOutput("seq FE", 32'(count), 32'hFE);
    advanceToTick(1'b0, waited);
    checkOutput("tick period 8", waited, 32'd7);
    applyStimulus();
    checkOutput("seq FF", 32'(count), 32'hFF);
    checkOutput("overflow before wrap", 32'(overflow), 32'h0);
    advanceToTick(1'b0, waited);
    clr_overflow = 1'b1;
    applyStimulus();
    clr_overflow = 1'b0;
    checkOutput("reload FD", 32'(count), 32'hFD);
    checkOutput("overflow set wins", 32'(overflow), 32'h1);

    // One-shot down count stops after the wrap, reload re-arms it
    one_shot = 1'b1; load = 1'b1; load_value = 8'h02; up_down = 1'b0;
    reload_en = 1'b0; clr_underflow = 1'b1;
    applyStimulus();
    load = 1'b0; clr_underflow = 1'b0;
    checkOutput("underflow cleared", 32'(underflow), 32'h0);
    for (int i = 0; i < 3; i++) begin
      advanceToTick(1'b0, waited); applyStimulus();
    end
    checkOutput("one-shot wrap count", 32'(count), 32'hFF);
    checkOutput("one-shot underflow", 32'(underflow), 32'h1);
    checkOutput("one-shot stopped", 32'(running), 32'h0);
    for (int i = 0; i < 20; i++) begin
      advanceToTick(1'b0, waited); applyStimulus();
    end
    checkOutput("one-shot hold", 32'(count), 32'hFF);
    load = 1'b1; load_value = 8'h05;
    applyStimulus();
    load = 1'b0;
    checkOutput("re-armed", 32'(running), 32'h1);
    advanceToTick(1'b0, waited); applyStimulus();
    checkOutput("resumed count", 32'(count), 32'h04);

    // Compare match on a step, never on a load
    one_shot = 1'b0; cks = 3'd1; up_down = 1'b1; cmp_value = 8'h03;
    load = 1'b1; load_value = 8'h00;
    applyStimulus();
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      advanceToTick(1'b0, waited); applyStimulus();
    end
    checkOutput("cmp before", 32'(cmp_match), 32'h0);
    advanceToTick(1'b0, waited); applyStimulus();
    checkOutput("cmp count 3", 32'(count), 32'h03);
    checkOutput("cmp set", 32'(cmp_match), 32'h1);
    clr_cmp = 1'b1;
    applyStimulus();
    clr_cmp = 1'b0;
    checkOutput("cmp cleared", 32'(cmp_match), 32'h0);
    load = 1'b1; load_value = 8'h03;
    applyStimulus();
    load = 1'b0;
    checkOutput("load 3 count", 32'(count), 32'h03);
    checkOutput("load no match", 32'(cmp_match), 32'h0);

    // Reset mid-count discards flags and one-shot state
    one_shot = 1'b1; load = 1'b1; load_value = 8'hFF;
    applyStimulus();
    load = 1'b0;
    advanceToTick(1'b0, waited); applyStimulus();
    checkOutput("pre-reset overflow", 32'(overflow), 32'h1);
    checkOutput("pre-reset stopped", 32'(running), 32'h0);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0; one_shot = 1'b0;
    checkOutput("mid reset count", 32'(count), 32'h0);
    checkOutput("mid reset flags", {29'd0, overflow, underflow, cmp_match}, 32'h0);
    checkOutput("mid reset running", 32'(running), 32'h1);
    advanceToTick(1'b0, waited);
    checkOutput("restart tick cycle", waited, 32'd3);

    // 12-bit instance: 16-clock ticks and overflow FFF -> 000
    b_cks = 2'd3; b_enable = 1'b1; b_load = 1'b1; b_load_value = 12'hFFE;
    applyStimulus();
    b_load = 1'b0;
    checkOutput("w12 load", 32'(b_count), 32'hFFE);
    advanceToTick(1'b1, waited); applyStimulus();
    checkOutput("w12 FFF", 32'(b_count), 32'hFFF);
    checkOutput("w12 no overflow", 32'(b_overflow), 32'h0);
    advanceToTick(1'b1, waited);
    checkOutput("w12 tick period 16", waited, 32'd15);
    applyStimulus();
    checkOutput("w12 wrap count", 32'(b_count), 32'h000);
    checkOutput("w12 overflow", 32'(b_overflow), 32'h1);

    repeat (4) applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule : tb_timer_counter_n
